apb_irq_counter_array: RTL and testbench
========================================

APB_IRQ_COUNTER_ARRAY -- requirements
Module: apb_irq_counter_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of counter channels (legal 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, counter/load width in bits (legal 8..32).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 PCLK  in  1  sole clock, all state on rising edge.
REQ-005 PRESET  in  1  asynchronous active-high reset.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-007 PADDR  in  32  byte address; bits [11:0] decoded, upper bits ignored.
REQ-008 PWDATA  in  32  write data.
REQ-009 PRDATA  out  32  read data.
REQ-010 PREADY  out  1  transfer complete.
REQ-011 PSLVERR  out  1  transfer error.
REQ-012 ack_in  in  NUM_CH  per-channel interrupt acknowledge, level.
REQ-013 irq_vec  out  NUM_CH  per-channel interrupt.
REQ-014 irq  out  1  OR of irq_vec.

Function
REQ-015 SHALL accept a transfer on every cycle with PSEL&&PENABLE, setup phase not required; PREADY=1 in that cycle, 0 otherwise; no wait states.
REQ-016 Register map, channel c base 0x10*c: 0x0 LOAD (RW, CNT_W LSBs), 0x4 CTRL, 0x8 COUNT (RO), 0xC STATUS.
REQ-017 CTRL: bit0 START (write-1 action, reads 0), bit1 IE (RW), bit2 RELOAD (RW), bit3 ABORT (write-1 action, reads 0).
REQ-018 STATUS: bit0 PENDING (W1C), bit1 BUSY (RO).
REQ-019 Unmapped address (channel >= NUM_CH, or offset outside map) or write to COUNT SHALL give PSLVERR=1 in the access cycle, no state change, PRDATA=0.
REQ-020 PRDATA SHALL be combinational from addressed register during read access, 0 otherwise; unused bits read 0.
REQ-021 Per-channel FSM states IDLE, COUNT, PEND.
REQ-022 IDLE: START write -> COUNT, COUNT register <= LOAD on same edge.
REQ-023 COUNT: decrement by 1 per cycle; in the cycle COUNT==0, next edge sets PENDING and goes PEND; irq_vec[c] first high LOAD+1 cycles after the START edge (LOAD=0 -> 1 cycle).
REQ-024 irq_vec[c] = PENDING & IE, combinational from registers.
REQ-025 PEND: ack_in[c]=1 or STATUS W1C clears PENDING at next edge -> IDLE; irq_vec[c] low the following cycle.
REQ-026 START while COUNT SHALL restart from current LOAD; START while PEND SHALL be ignored.
REQ-027 ABORT in any state -> IDLE, COUNT <= 0; PENDING unchanged.
REQ-028 LOAD write while counting SHALL not affect the running count; used at next START/reload.
REQ-029 Expiry and clear (ack or W1C) on the same edge: set wins, PENDING stays 1.
REQ-030 BUSY = (state==COUNT).

Reset
REQ-031 PRESET SHALL immediately force all channels IDLE, LOAD/COUNT/CTRL/PENDING=0, irq_vec=0, irq=0, PSLVERR=0, PREADY=0, PRDATA=0, including mid-count and mid-transfer.

Configuration
REQ-032 Macro AUTO_RELOAD_EN defined: RELOAD=1 at expiry SHALL set PENDING, reload COUNT <= LOAD and stay COUNT (periodic); PENDING cleared by ack/W1C without leaving COUNT.
REQ-033 AUTO_RELOAD_EN undefined: CTRL bit2 reads 0, writes ignored, always one-shot per REQ-023.

Structure
REQ-034 Package apb_irq_cnt_pkg SHALL hold the state enum, register offsets, CTRL/STATUS bit indices and map size constants.
REQ-035 Sub-module irq_cnt_channel SHALL implement one channel (LOAD, CTRL, COUNT, FSM, PENDING), instantiated NUM_CH times by generate; top holds APB decode and read mux.

Verification
REQ-036 LOAD0=5, CTRL0=0x3 -> irq_vec[0] and irq high 6 cycles after START edge, COUNT0 reads 0, STATUS0=0x1.
REQ-037 Pending ch0, ack_in[0]=1 one cycle -> irq low next cycle, STATUS0=0x0; repeat 5 iterations, each identical latency.
REQ-038 Ch1 LOAD=3, ch2 LOAD=7, both started same cycle, IE=1 -> irq_vec=0b0010 at +4, 0b0110 at +8; ack ch1 only -> irq stays 1.
REQ-039 Read 0x10*NUM_CH and write 0x8 -> PSLVERR=1, PRDATA=0, registers unchanged.
REQ-040 PRESET asserted with ch0 COUNT=2 -> irq, COUNT, state 0 at once; no irq after release.
REQ-041 AUTO_RELOAD_EN, LOAD=2, CTRL=0x7 -> PENDING set every 3 cycles; ack on an expiry edge leaves PENDING=1.

Source files
------------

// File: rtl/apb_irq_cnt_pkg.sv
// rtl/apb_irq_cnt_pkg.sv - shared types and register map constants for the APB interrupt counter array
package apb_irq_cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_PEND  = 2'd2
    } ch_state_t;

    // Decoded address window and per-channel register block size
    localparam int DEC_W    = 12;
    localparam int CH_SHIFT = 4;
    localparam int CH_IDX_W = DEC_W - CH_SHIFT;

    localparam logic [3:0] OFF_LOAD   = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_RELOAD = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int STAT_PENDING = 0;
    localparam int STAT_BUSY    = 1;

    // Every word-aligned offset inside a channel block is a real register
    function automatic logic off_mapped(input logic [3:0] off);
        return off[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/apb_irq_counter_array_if.sv
// rtl/apb_irq_counter_array_if.sv - APB bus bundle for the interrupt counter array
interface apb_irq_counter_array_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/irq_cnt_channel.sv
// rtl/irq_cnt_channel.sv - one down-counter channel with pending interrupt; AUTO_RELOAD_EN enables periodic reload
module irq_cnt_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_we,
    input  logic             ctrl_we,
    input  logic             status_we,
    input  logic [CNT_W-1:0] wdata,
    input  logic             ack,
    output logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] count,
    output logic             ie,
    output logic             reload,
    output logic             pending,
    output logic             busy,
    output logic             irq
);
    import apb_irq_cnt_pkg::*;

    ch_state_t state;
    logic      start;
    logic      abort;
    logic      clr;
    logic      expire;

    assign start  = ctrl_we & wdata[CTRL_START];
    assign abort  = ctrl_we & wdata[CTRL_ABORT];
    assign clr    = ack | (status_we & wdata[STAT_PENDING]);
    // A restart or abort on the terminal cycle pre-empts the expiry
    assign expire = (state == ST_COUNT) && (count == '0) && !start && !abort;

    assign busy = (state == ST_COUNT);
    assign irq  = pending & ie;

`ifdef AUTO_RELOAD_EN
    logic reload_q;
    assign reload = reload_q;
`else
    assign reload = 1'b0;
`endif

    // Register file, pending flag and IDLE/COUNT/PEND sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            load    <= '0;
            count   <= '0;
            ie      <= 1'b0;
            pending <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q <= 1'b0;
`endif
        end else begin
            if (load_we) begin
                load <= wdata;
            end
            if (ctrl_we) begin
                ie <= wdata[CTRL_IE];
`ifdef AUTO_RELOAD_EN
                reload_q <= wdata[CTRL_RELOAD];
`endif
            end
            // Setting on expiry wins over a simultaneous clear
            if (expire) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
            if (abort) begin
                state <= ST_IDLE;
                count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_COUNT;
                            count <= load;
                        end
                    end
                    ST_COUNT: begin
                        if (start) begin
                            count <= load;
                        end else if (count == '0) begin
                            if (reload) begin
                                count <= load;
                            end else begin
                                state <= ST_PEND;
                            end
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                    ST_PEND: begin
                        if (clr) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/apb_irq_counter_array.sv
// rtl/apb_irq_counter_array.sv - APB-mapped array of interrupt down-counters; AUTO_RELOAD_EN enables periodic mode
module apb_irq_counter_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_irq_counter_array_if.slave apb,
    input  logic [NUM_CH-1:0]     ack_in,
    output logic [NUM_CH-1:0]     irq_vec,
    output logic                  irq
);
    import apb_irq_cnt_pkg::*;

    logic                access;
    logic [CH_IDX_W-1:0] ch_idx;
    logic [3:0]          off;
    logic                mapped;
    logic                err;
    logic                wr_ok;
    logic                rd_ok;
    logic [31:0]         rdata;
    logic                unused_bits;

    logic [NUM_CH-1:0]   load_we;
    logic [NUM_CH-1:0]   ctrl_we;
    logic [NUM_CH-1:0]   status_we;
    logic [NUM_CH-1:0]   ie_a;
    logic [NUM_CH-1:0]   reload_a;
    logic [NUM_CH-1:0]   pend_a;
    logic [NUM_CH-1:0]   busy_a;
    logic [CNT_W-1:0]    load_a  [NUM_CH];
    logic [CNT_W-1:0]    count_a [NUM_CH];
    logic [31:0]         rd_val  [NUM_CH];

    assign access = apb.PSEL & apb.PENABLE;
    assign ch_idx = apb.PADDR[DEC_W-1:CH_SHIFT];
    assign off    = apb.PADDR[CH_SHIFT-1:0];
    assign mapped = (int'(ch_idx) < NUM_CH) && off_mapped(off);
    assign err    = access && (!mapped || (apb.PWRITE && off == OFF_COUNT));
    assign wr_ok  = access && apb.PWRITE && !err;
    assign rd_ok  = access && !apb.PWRITE && !err;

    // Reset forces the bus outputs low even while a transfer is presented
    assign apb.PREADY  = access & !PRESET;
    assign apb.PSLVERR = err & !PRESET;
    assign apb.PRDATA  = PRESET ? 32'd0 : rdata;
    assign irq         = |irq_vec;

    assign unused_bits = ^{apb.PADDR[31:DEC_W], apb.PWDATA};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit          = wr_ok && (ch_idx == CH_IDX_W'(c));
        assign load_we[c]   = hit && (off == OFF_LOAD);
        assign ctrl_we[c]   = hit && (off == OFF_CTRL);
        assign status_we[c] = hit && (off == OFF_STATUS);

        assign rd_val[c] =
            (off == OFF_LOAD)   ? 32'(load_a[c]) :
            (off == OFF_CTRL)   ? {29'd0, reload_a[c], ie_a[c], 1'b0} :
            (off == OFF_COUNT)  ? 32'(count_a[c]) :
            (off == OFF_STATUS) ? {30'd0, busy_a[c], pend_a[c]} : 32'd0;

        irq_cnt_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (PCLK),
            .rst       (PRESET),
            .load_we   (load_we[c]),
            .ctrl_we   (ctrl_we[c]),
            .status_we (status_we[c]),
            .wdata     (apb.PWDATA[CNT_W-1:0]),
            .ack       (ack_in[c]),
            .load      (load_a[c]),
            .count     (count_a[c]),
            .ie        (ie_a[c]),
            .reload    (reload_a[c]),
            .pending   (pend_a[c]),
            .busy      (busy_a[c]),
            .irq       (irq_vec[c])
        );
    end

    // Read mux: only a valid read access drives data, everything else reads zero
    always_comb begin
        rdata = 32'd0;
        if (rd_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == CH_IDX_W'(c)) begin
                    rdata = rd_val[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_irq_counter_array.sv
// tb/tb_apb_irq_counter_array.sv - scoreboard bench for apb_irq_counter_array
module tb_apb_irq_counter_array;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
`ifdef AUTO_RELOAD_EN
    localparam bit HAS_RELOAD = 1'b1;
`else
    localparam bit HAS_RELOAD = 1'b0;
`endif

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NUM_CH-1:0] ack_in;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;

    apb_irq_counter_array_if apb();

    apb_irq_counter_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .apb     (apb),
        .ack_in  (ack_in),
        .irq_vec (irq_vec),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { logic [NUM_CH-1:0] iv; logic rdy; } cyc_exp_t;
    typedef struct { logic [31:0] rdata; logic err; } txn_exp_t;
    cyc_exp_t cyc_q[$];
    txn_exp_t txn_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: a channel is "running" since start cycle m_start with period m_runload+1
    int               cyc;
    logic [CNT_W-1:0] m_load    [NUM_CH];
    bit               m_ie      [NUM_CH];
    bit               m_reload  [NUM_CH];
    bit               m_pending [NUM_CH];
    bit               m_running [NUM_CH];
    bit               m_blocked [NUM_CH];
    int               m_start   [NUM_CH];
    int               m_runload [NUM_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_load[c] = '0; m_ie[c] = 0; m_reload[c] = 0; m_pending[c] = 0;
            m_running[c] = 0; m_blocked[c] = 0; m_start[c] = 0; m_runload[c] = 0;
        end
    endtask

    function automatic int m_count(input int c);
        if (!m_running[c]) return 0;
        return m_runload[c] - ((cyc - m_start[c]) % (m_runload[c] + 1));
    endfunction

    function automatic logic [NUM_CH-1:0] m_irqv();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_pending[c] & m_ie[c];
        return v;
    endfunction

    task automatic decode(input logic [31:0] addr, input bit wr, output int ch, output int off, output bit err);
        ch  = int'(addr[11:4]);
        off = int'(addr[3:0]);
        err = !(ch < NUM_CH && (off % 4) == 0) || (wr && off == 8);
    endtask

    function automatic logic [31:0] m_read(input int c, input int off);
        case (off)
            0:  return 32'(m_load[c]);
            4:  return {29'd0, m_reload[c], m_ie[c], 1'b0};
            8:  return 32'(m_count(c));
            12: return {30'd0, m_running[c], m_pending[c]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit access, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [NUM_CH-1:0] ack);
        int ch, off, e;
        bit err, wr_ok, hit, st, ab, cl, ex, bp;
        logic [CNT_W-1:0] lp;
        e = cyc + 1;
        decode(addr, wr, ch, off, err);
        wr_ok = access && wr && !err;
        for (int c = 0; c < NUM_CH; c++) begin
            hit = wr_ok && ch == c;
            st  = hit && off == 4 && wdata[0];
            ab  = hit && off == 4 && wdata[3];
            cl  = ack[c] || (hit && off == 12 && wdata[0]);
            ex  = m_running[c] && m_count(c) == 0 && !st && !ab;
            bp  = m_blocked[c];
            lp  = m_load[c];
            if (ex) begin
                m_pending[c] = 1;
                if (HAS_RELOAD && m_reload[c]) begin
                    m_start[c] = e; m_runload[c] = int'(lp);
                end else begin
                    m_running[c] = 0; m_blocked[c] = 1;
                end
            end else if (cl) begin
                m_pending[c] = 0; m_blocked[c] = 0;
            end
            if (ab) begin
                m_running[c] = 0; m_blocked[c] = 0;
            end else if (st && !bp) begin
                m_running[c] = 1; m_start[c] = e; m_runload[c] = int'(lp);
            end
            if (hit && off == 0) m_load[c] = wdata[CNT_W-1:0];
            if (hit && off == 4) begin
                m_ie[c]     = wdata[1];
                m_reload[c] = HAS_RELOAD ? wdata[2] : 1'b0;
            end
        end
        cyc = e;
    endtask

    // Drive one bus cycle, queue its expected outputs, then advance the model over the edge
    task automatic do_cycle(input bit sel, input bit en, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [NUM_CH-1:0] ack);
        cyc_exp_t ce;
        txn_exp_t te;
        int ch, off;
        bit err;
        apb.PSEL = sel; apb.PENABLE = en; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata; ack_in = ack;
        decode(addr, wr, ch, off, err);
        ce.iv = m_irqv(); ce.rdy = sel && en;
        cyc_q.push_back(ce);
        if (sel && en) begin
            te.err = err;
            te.rdata = (err || wr) ? 32'd0 : m_read(ch, off);
            txn_q.push_back(te);
        end
        @(posedge PCLK);
        model_step(sel && en, wr, addr, wdata, ack);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] d);
        do_cycle(1, 1, 1, addr, d, '0);
    endtask

    task automatic rd_reg(input logic [31:0] addr);
        do_cycle(1, 1, 0, addr, 32'd0, '0);
    endtask

    task automatic idle(input logic [NUM_CH-1:0] ack);
        do_cycle(0, 0, 0, 32'd0, 32'd0, ack);
    endtask

    task automatic wait_irq(input int c, input int lim, output int lat);
        lat = -1;
        for (int k = 1; k <= lim; k++) begin
            idle('0);
            if (irq_vec[c] === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic rand_cycle();
        int r, ch, off;
        logic [31:0] a, d;
        logic [NUM_CH-1:0] ak;
        r   = $urandom_range(0, 9);
        ch  = $urandom_range(0, NUM_CH);
        off = $urandom_range(0, 15);
        off = (off < 15) ? (off % 4) * 4 : $urandom_range(0, 15);
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a[31:12] = '0;
        a[11:4] = 8'(ch); a[3:0] = 4'(off);
        d = $urandom;
        if (off == 0) d = $urandom_range(0, 9);
        d[3] = ($urandom_range(0, 15) == 0);
        for (int c = 0; c < NUM_CH; c++) ak[c] = ($urandom_range(0, 7) == 0);
        if (r < 2)      do_cycle(0, 0, 0, a, d, ak);
        else if (r < 3) do_cycle(1, 0, $urandom_range(0, 1) == 1, a, d, ak);
        else            do_cycle(1, 1, $urandom_range(0, 1) == 1, a, d, ak);
    endtask

    // Monitor: pop expectations whenever the DUT presents a cycle or a completed transfer
    initial begin
        cyc_exp_t ce;
        txn_exp_t te;
        forever begin
            @(negedge PCLK);
            if (PRESET === 1'b0) begin
                if (cyc_q.size() > 0) begin
                    ce = cyc_q.pop_front();
                    chk("irq_vec", 32'(irq_vec), 32'(ce.iv));
                    chk("irq", 32'(irq), 32'(|ce.iv));
                    chk("pready", 32'(apb.PREADY), 32'(ce.rdy));
                end
                if (apb.PREADY === 1'b1) begin
                    if (txn_q.size() == 0) begin
                        chk("unexpected_pready", 32'(txn_q.size()), 32'd1);
                    end else begin
                        te = txn_q.pop_front();
                        chk("prdata", apb.PRDATA, te.rdata);
                        chk("pslverr", 32'(apb.PSLVERR), 32'(te.err));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        cyc = 0;
        model_reset();
        PRESET = 1'b1; ack_in = '0;
        apb.PSEL = 1; apb.PENABLE = 1; apb.PWRITE = 0; apb.PADDR = 32'h8; apb.PWDATA = 0;
        #12;
        chk("rst_pready", 32'(apb.PREADY), 32'd0);
        chk("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
        chk("rst_prdata", apb.PRDATA, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_vec", 32'(irq_vec), 32'd0);
        apb.PSEL = 0; apb.PENABLE = 0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 16; o += 4) rd_reg(32'(16 * c + o));

        // LOAD=5, IE+START: interrupt six cycles after the start edge
        wr_reg(32'h0, 32'd5);
        wr_reg(32'h4, 32'h3);
        wait_irq(0, 20, lat);
        chk("start_to_irq_lat", 32'(lat), 32'd6);
        chk("irq_after_expiry", 32'(irq), 32'd1);
        rd_reg(32'h8);
        rd_reg(32'hC);

        // Acknowledge drops the interrupt after one edge, repeatably
        for (int i = 0; i < 5; i++) begin
            idle(4'b0001);
            chk($sformatf("ack_drop_%0d", i), 32'(irq), 32'd0);
            rd_reg(32'hC);
            wr_reg(32'h4, 32'h3);
            wait_irq(0, 20, lat);
            chk($sformatf("restart_lat_%0d", i), 32'(lat), 32'd6);
        end
        idle(4'b0001);

        // Two channels running together; ack one leaves the other asserting irq
        wr_reg(32'h10, 32'd3);
        wr_reg(32'h20, 32'd7);
        wr_reg(32'h24, 32'h3);
        wr_reg(32'h14, 32'h3);
        wait_irq(1, 20, lat);
        chk("ch1_lat", 32'(lat), 32'd4);
        chk("vec_ch1_only", 32'(irq_vec), 32'b0010);
        wait_irq(2, 20, lat);
        chk("ch2_lat_after_ch1", 32'(lat), 32'd3);
        chk("vec_ch1_ch2", 32'(irq_vec), 32'b0110);
        idle(4'b0010);
        chk("irq_stays_ch2", 32'(irq), 32'd1);
        wr_reg(32'h2C, 32'h1);

        // Unmapped channel, misaligned offset and COUNT write all error with no side effect
        rd_reg(32'(16 * NUM_CH));
        wr_reg(32'h8, 32'h55);
        wr_reg(32'h2, 32'h1);
        rd_reg(32'h0);
        rd_reg(32'h8);

        // Reset in the middle of a count and a transfer
        wr_reg(32'hC, 32'h1);
        wr_reg(32'h4, 32'h8);
        wr_reg(32'h0, 32'd4);
        wr_reg(32'h4, 32'h3);
        for (int k = 0; k < 10 && m_count(0) != 2; k++) idle('0);
        chk("pre_reset_count", 32'(m_count(0)), 32'd2);
        apb.PSEL = 1; apb.PENABLE = 1; apb.PWRITE = 0; apb.PADDR = 32'h8;
        #1 PRESET = 1'b1;
        #1;
        chk("midrst_pready", 32'(apb.PREADY), 32'd0);
        chk("midrst_prdata", apb.PRDATA, 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        apb.PSEL = 0; apb.PENABLE = 0;
        @(posedge PCLK); #2;
        PRESET = 1'b0;
        model_reset();
        rd_reg(32'h8);
        rd_reg(32'hC);
        for (int k = 0; k < 10; k++) idle('0);
        chk("no_irq_after_reset", 32'(irq), 32'd0);

`ifdef AUTO_RELOAD_EN
        // Periodic mode: expiry every LOAD+1 cycles, ack on an expiry edge loses to the set
        wr_reg(32'h0, 32'd2);
        wr_reg(32'h4, 32'h7);
        for (int k = 0; k < 12; k++) begin
            if (m_running[0] && m_count(0) == 0) begin
                idle(4'b0001);
                chk("ack_on_expiry_pending", 32'(m_pending[0]), 32'd1);
            end else begin
                idle('0);
            end
            rd_reg(32'hC);
        end
        wr_reg(32'h4, 32'h8);
`endif

        for (int k = 0; k < 1500; k++) rand_cycle();

        idle('0);
        idle('0);
        chk("txn_queue_drained", 32'(txn_q.size()), 32'd0);
        chk("cyc_queue_drained", 32'(cyc_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
